// File: rtl/regfile_wport_arbiter_if.sv
// Request/response bundle around the shared register-file write port.
// slave  : the arbiter (consumes requests, drives grants and the rf write port)
// master : the requesters/pipeline side (drives requests, observes grants)
interface regfile_wport_arbiter_if;
  // pipeline writeback
  logic       pipe_we;
  logic [2:0] pipe_rd;
  logic [7:0] pipe_data;
  // multi-cycle unit result return
  logic       mu_valid;
  logic [2:0] mu_rd;
  logic [7:0] mu_data;
  logic       mu_ready;
  // debug/host write
  logic       dbg_req;
  logic [2:0] dbg_rd;
  logic [7:0] dbg_data;
  logic       dbg_ack;
  // register-file write port and pipeline feedback
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [7:0] pend_mask;
  logic       stall_req;

  modport slave (
    input  pipe_we, pipe_rd, pipe_data,
    input  mu_valid, mu_rd, mu_data,
    output mu_ready,
    input  dbg_req, dbg_rd, dbg_data,
    output dbg_ack,
    output rf_we, rf_waddr, rf_wdata,
    output pend_mask, stall_req
  );

  modport master (
    output pipe_we, pipe_rd, pipe_data,
    output mu_valid, mu_rd, mu_data,
    input  mu_ready,
    output dbg_req, dbg_rd, dbg_data,
    input  dbg_ack,
    input  rf_we, rf_waddr, rf_wdata,
    input  pend_mask, stall_req
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Arbitrates the single 8-bit register-file write port between pipeline
// writeback (highest), buffered multi-cycle unit results, and debug writes.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset
//   bus    - slave side of regfile_wport_arbiter_if: requests in, mu_ready,
//            dbg_ack (comb), rf_we/rf_waddr/rf_wdata (registered),
//            pend_mask (comb from FIFO state), stall_req (registered)
module regfile_wport_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_wport_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned STV_W = 4;

  // FIFO storage and state
  logic [2:0]       rd_mem   [DEPTH];
  logic [7:0]       data_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q,  count_d;

  // starvation tracking
  logic [STV_W-1:0] starve_q, starve_d;
  logic             pop_q;
  logic             stall_q;

  // registered write port
  logic             rf_we_q;
  logic [2:0]       rf_waddr_q;
  logic [7:0]       rf_wdata_q;

  // combinational decisions
  logic             fifo_empty, fifo_ready;
  logic             push, pop, dbg_grant;
  logic             wr_en_d;
  logic [2:0]       wr_addr_d;
  logic [7:0]       wr_data_d;
  logic [7:0]       pend_c;
  logic [PTR_W-1:0] idx;

  // Priority: pipe > FIFO head > debug (debug only with FIFO empty)
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_ready = (count_q < CNT_W'(DEPTH));
    push       = bus.mu_valid && fifo_ready;
    pop        = !bus.pipe_we && !fifo_empty;
    dbg_grant  = bus.dbg_req && !bus.pipe_we && fifo_empty;

    wr_en_d   = 1'b0;
    wr_addr_d = rf_waddr_q;
    wr_data_d = rf_wdata_q;
    if (bus.pipe_we) begin
      wr_en_d   = 1'b1;
      wr_addr_d = bus.pipe_rd;
      wr_data_d = bus.pipe_data;
    end else if (pop) begin
      wr_en_d   = 1'b1;
      wr_addr_d = rd_mem[rd_ptr_q];
      wr_data_d = data_mem[rd_ptr_q];
    end else if (dbg_grant) begin
      wr_en_d   = 1'b1;
      wr_addr_d = bus.dbg_rd;
      wr_data_d = bus.dbg_data;
    end

    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    // counts cycles a non-empty FIFO loses to the pipeline, saturating
    starve_d = starve_q;
    if (fifo_empty || pop)
      starve_d = '0;
    else if (bus.pipe_we && (starve_q != STV_W'(STARVE_LIMIT)))
      starve_d = starve_q + 1'b1;
  end

  // Pending-destination mask over the live FIFO window
  always_comb begin
    pend_c = '0;
    idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if (CNT_W'(k) < count_q)
        pend_c[rd_mem[idx]] = 1'b1;
    end
  end

  // FIFO payload storage; no reset needed, validity comes from count_q
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= bus.mu_rd;
      data_mem[wr_ptr_q] <= bus.mu_data;
    end
  end

  // Control state, write port and stall request
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      pop_q      <= 1'b0;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_d;
      starve_q <= starve_d;
      pop_q    <= pop;
      rf_we_q  <= wr_en_d;
      if (wr_en_d) begin
        rf_waddr_q <= wr_addr_d;
        rf_wdata_q <= wr_data_d;
      end
      // stall drops one edge after the pop that relieved the FIFO
      if (starve_d == STV_W'(STARVE_LIMIT))
        stall_q <= 1'b1;
      else if (pop_q)
        stall_q <= 1'b0;
    end
  end

  assign bus.mu_ready  = fifo_ready;
  assign bus.dbg_ack   = dbg_grant;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.pend_mask = pend_c;
  assign bus.stall_req = stall_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_regfile_wport_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  regfile_wport_arbiter_if bus ();

  regfile_wport_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // advance one cycle; sample #1 after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [2:0] a, input logic [7:0] d);
    chk({tag, ".we"},    32'(bus.rf_we),    32'd1);
    chk({tag, ".waddr"}, 32'(bus.rf_waddr), 32'(a));
    chk({tag, ".wdata"}, 32'(bus.rf_wdata), 32'(d));
  endtask

  task automatic pipe(input logic we, input logic [2:0] rd, input logic [7:0] d);
    bus.pipe_we = we; bus.pipe_rd = rd; bus.pipe_data = d;
  endtask

  task automatic mu(input logic v, input logic [2:0] rd, input logic [7:0] d);
    bus.mu_valid = v; bus.mu_rd = rd; bus.mu_data = d;
  endtask

  initial begin
    reset = 1'b1;
    pipe(1'b0, 3'd0, 8'h00);
    mu(1'b0, 3'd0, 8'h00);
    bus.dbg_req = 1'b0; bus.dbg_rd = 3'd0; bus.dbg_data = 8'h00;
    tick(); tick();
    reset = 1'b0;

    // reset state
    chk("rst.we",     32'(bus.rf_we),     32'd0);
    chk("rst.waddr",  32'(bus.rf_waddr),  32'd0);
    chk("rst.wdata",  32'(bus.rf_wdata),  32'd0);
    chk("rst.stall",  32'(bus.stall_req), 32'd0);
    chk("rst.pend",   32'(bus.pend_mask), 32'h00);
    chk("rst.ready",  32'(bus.mu_ready),  32'd1);

    // single pipeline write, then idle with held address/data
    pipe(1'b1, 3'd5, 8'h3C);
    tick();
    pipe(1'b0, 3'd0, 8'h00);
    chk_wr("pipe", 3'd5, 8'h3C);
    tick();
    chk("idle.we",    32'(bus.rf_we),    32'd0);
    chk("idle.waddr", 32'(bus.rf_waddr), 32'd5);
    chk("idle.wdata", 32'(bus.rf_wdata), 32'h3C);

    // two buffered results (pipe kept busy on r1 so both stay queued)
    pipe(1'b1, 3'd1, 8'h01); mu(1'b1, 3'd2, 8'h11);
    tick();
    chk("push1.pend", 32'(bus.pend_mask), 32'h04);
    chk_wr("push1.pipe", 3'd1, 8'h01);
    pipe(1'b1, 3'd1, 8'h02); mu(1'b1, 3'd6, 8'h22);
    tick();
    chk("push2.pend",  32'(bus.pend_mask), 32'h44);
    chk("push2.ready", 32'(bus.mu_ready),  32'd0);
    pipe(1'b0, 3'd0, 8'h00); mu(1'b0, 3'd0, 8'h00);
    tick();
    chk_wr("drain1", 3'd2, 8'h11);
    chk("drain1.pend",  32'(bus.pend_mask), 32'h40);
    chk("drain1.ready", 32'(bus.mu_ready),  32'd1);
    tick();
    chk_wr("drain2", 3'd6, 8'h22);
    chk("drain2.pend", 32'(bus.pend_mask), 32'h00);
    tick();
    chk("drain.idle", 32'(bus.rf_we), 32'd0);

    // starvation: r3 buffered, pipe wins continuously
    pipe(1'b1, 3'd0, 8'h55); mu(1'b1, 3'd3, 8'h33);
    tick();
    mu(1'b0, 3'd0, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("starve%0d.stall", i), 32'(bus.stall_req), 32'd0);
    end
    tick();
    chk("starve4.stall", 32'(bus.stall_req), 32'd1);
    chk_wr("starve4.pipe", 3'd0, 8'h55);
    tick();
    chk("starve5.stall", 32'(bus.stall_req), 32'd1);
    pipe(1'b0, 3'd0, 8'h00);
    tick();
    chk_wr("starve.pop", 3'd3, 8'h33);
    chk("starve.pop.stall", 32'(bus.stall_req), 32'd1);
    tick();
    chk("starve.clr.stall", 32'(bus.stall_req), 32'd0);
    chk("starve.clr.we",    32'(bus.rf_we),     32'd0);

    // debug waits for the FIFO to drain
    pipe(1'b1, 3'd4, 8'h44); mu(1'b1, 3'd1, 8'h77);
    bus.dbg_req = 1'b1; bus.dbg_rd = 3'd7; bus.dbg_data = 8'hA5;
    #1;
    chk("dbg.ack.pipe", 32'(bus.dbg_ack), 32'd0);
    tick();
    pipe(1'b0, 3'd0, 8'h00); mu(1'b0, 3'd0, 8'h00);
    #1;
    chk("dbg.ack.fifo", 32'(bus.dbg_ack), 32'd0);
    tick();
    chk_wr("dbg.fifo", 3'd1, 8'h77);
    chk("dbg.ack.on", 32'(bus.dbg_ack), 32'd1);
    tick();
    bus.dbg_req = 1'b0;
    #1;
    chk_wr("dbg.write", 3'd7, 8'hA5);
    chk("dbg.ack.off", 32'(bus.dbg_ack), 32'd0);
    tick();
    chk("dbg.idle", 32'(bus.rf_we), 32'd0);

    // full FIFO: push attempted during pop is refused, then accepted
    pipe(1'b1, 3'd0, 8'h01); mu(1'b1, 3'd2, 8'h12);
    tick();
    pipe(1'b1, 3'd0, 8'h02); mu(1'b1, 3'd4, 8'h14);
    tick();
    pipe(1'b0, 3'd0, 8'h00); mu(1'b1, 3'd5, 8'h15);
    #1;
    chk("full.ready", 32'(bus.mu_ready), 32'd0);
    tick();
    chk_wr("full.pop1", 3'd2, 8'h12);
    chk("full.pop1.pend",  32'(bus.pend_mask), 32'h10);
    chk("full.pop1.ready", 32'(bus.mu_ready),  32'd1);
    tick();
    mu(1'b0, 3'd0, 8'h00);
    chk_wr("full.pop2", 3'd4, 8'h14);
    chk("full.pop2.pend", 32'(bus.pend_mask), 32'h20);
    tick();
    chk_wr("full.pop3", 3'd5, 8'h15);
    chk("full.pop3.pend", 32'(bus.pend_mask), 32'h00);
    tick();

    // reset with two results buffered and stall asserted
    pipe(1'b1, 3'd0, 8'h09); mu(1'b1, 3'd6, 8'h66);
    tick();
    mu(1'b1, 3'd7, 8'h77);
    tick();
    mu(1'b0, 3'd0, 8'h00);
    tick(); tick(); tick();
    chk("pre.stall", 32'(bus.stall_req), 32'd1);
    chk("pre.pend",  32'(bus.pend_mask), 32'hC0);
    chk("pre.ready", 32'(bus.mu_ready),  32'd0);
    reset = 1'b1;
    pipe(1'b0, 3'd0, 8'h00);
    tick();
    reset = 1'b0;
    chk("mid.pend",  32'(bus.pend_mask), 32'h00);
    chk("mid.stall", 32'(bus.stall_req), 32'd0);
    chk("mid.ready", 32'(bus.mu_ready),  32'd1);
    chk("mid.we",    32'(bus.rf_we),     32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post%0d.we", i), 32'(bus.rf_we), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
